// File: rtl/fu_sched_if.sv
// Issue-side and CDB-side bundle for the FU occupancy scheduler.
// master drives issue ways; slave reports busy, grants and CDB slots.
interface fu_sched_if #(
  parameter int WAYS  = 3,
  parameter int CDB_W = 3
);
  logic [WAYS-1:0]       issue_valid;
  logic [WAYS-1:0][2:0]  issue_fu;
  logic [5:0]            fu_busy;
  logic [5:0]            cdb_grant;
  logic [CDB_W-1:0]      cdb_valid;
  logic [CDB_W-1:0][2:0] cdb_fu;
  logic                  issue_err;

  modport master (
    output issue_valid,
    output issue_fu,
    input  fu_busy,
    input  cdb_grant,
    input  cdb_valid,
    input  cdb_fu,
    input  issue_err
  );

  modport slave (
    input  issue_valid,
    input  issue_fu,
    output fu_busy,
    output cdb_grant,
    output cdb_valid,
    output cdb_fu,
    output issue_err
  );
endinterface

// File: rtl/fu_sched_ctrl.sv
// Tracks six FUs from issue to CDB broadcast, arbitrates CDB slots
// and reports per-FU busy back to the reservation station.
module fu_sched_ctrl #(
  parameter int SUPERSCALAR_WAYS = 3,
  parameter int CDB_W            = 3,
  parameter int MULT_LAT         = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       squash,
  fu_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } st_e;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_LAT - 2);

  st_e        st_q  [6];
  st_e        st_d  [6];
  logic [3:0] cnt_q [6];
  logic [3:0] cnt_d [6];

  logic [5:0]            grant;
  logic [5:0]            busy;
  logic [5:0]            acc;
  logic                  err_set;
  logic                  err_q;
  logic [CDB_W-1:0]      cv;
  logic [CDB_W-1:0][2:0] cf;

  function automatic logic is_mult(input int f);
    return (f == 3) || (f == 4);
  endfunction

  // CDB priority: multipliers first, then branch, then ALUs
  function automatic int prio_fu(input int p);
    int f;
    unique case (p)
      0:       f = 3;
      1:       f = 4;
      2:       f = 5;
      3:       f = 0;
      4:       f = 1;
      default: f = 2;
    endcase
    return f;
  endfunction

  function automatic logic [5:0] code_oh(input logic [2:0] c);
    logic [5:0] oh;
    oh = '0;
    unique case (1'b1)
      (c == 3'd1): oh = 6'b000001;
      (c == 3'd2): oh = 6'b000010;
      (c == 3'd3): oh = 6'b000100;
      (c == 3'd4): oh = 6'b001000;
      (c == 3'd5): oh = 6'b010000;
      (c == 3'd6): oh = 6'b100000;
      default:     oh = '0;
    endcase
    return oh;
  endfunction

  always_comb begin
    int slot;
    grant = '0;
    cv    = '0;
    cf    = '0;
    slot  = 0;
    if (!squash) begin
      for (int p = 0; p < 6; p++) begin
        if (st_q[prio_fu(p)] == DONE && slot < CDB_W) begin
          grant[prio_fu(p)] = 1'b1;
          cv[slot]          = 1'b1;
          cf[slot]          = 3'(prio_fu(p) + 1);
          slot              = slot + 1;
        end
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int f = 0; f < 6; f++) begin
      busy[f] = (st_q[f] != IDLE) &&
                !(st_q[f] == DONE && grant[f]);
    end
  end

  // a way loses to any lower way aiming at the same legal FU
  always_comb begin
    logic [5:0] oh;
    logic [5:0] seen;
    acc     = '0;
    err_set = 1'b0;
    seen    = '0;
    oh      = '0;
    if (!squash) begin
      for (int j = 0; j < SUPERSCALAR_WAYS; j++) begin
        oh = bus.issue_valid[j] ? code_oh(bus.issue_fu[j]) : '0;
        if (|oh) begin
          if (|(oh & (busy | seen))) begin
            err_set = 1'b1;
          end else begin
            acc = acc | oh;
          end
          seen = seen | oh;
        end
      end
    end
  end

  always_comb begin
    for (int f = 0; f < 6; f++) begin
      st_d[f]  = st_q[f];
      cnt_d[f] = cnt_q[f];
      if (squash) begin
        st_d[f]  = IDLE;
        cnt_d[f] = '0;
      end else begin
        unique case (st_q[f])
          IDLE: begin
            if (acc[f]) begin
              st_d[f]  = is_mult(f) ? EXEC : DONE;
              cnt_d[f] = is_mult(f) ? MULT_LOAD : 4'd0;
            end
          end
          EXEC: begin
            if (cnt_q[f] != 4'd0) begin
              cnt_d[f] = cnt_q[f] - 4'd1;
            end else begin
              st_d[f] = DONE;
            end
          end
          DONE: begin
            if (grant[f]) begin
              st_d[f]  = IDLE;
              cnt_d[f] = '0;
              if (acc[f]) begin
                st_d[f]  = is_mult(f) ? EXEC : DONE;
                cnt_d[f] = is_mult(f) ? MULT_LOAD : 4'd0;
              end
            end
          end
          default: begin
            st_d[f]  = IDLE;
            cnt_d[f] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int f = 0; f < 6; f++) begin
        st_q[f]  <= IDLE;
        cnt_q[f] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int f = 0; f < 6; f++) begin
        st_q[f]  <= st_d[f];
        cnt_q[f] <= cnt_d[f];
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.fu_busy   = busy;
  assign bus.cdb_grant = grant;
  assign bus.cdb_valid = cv;
  assign bus.cdb_fu    = cf;
  assign bus.issue_err = err_q;

endmodule

// File: doc/fu_sched_ctrl.md
Name: fu_sched_ctrl

Overview:
Function-unit occupancy and write-back scheduler for the issue stage. It tracks the six execution units (alu_1, alu_2, alu_3, mult_1, mult_2, branch_1) from issue to CDB broadcast. It arbitrates finished units onto the CDB_W result-bus slots and drives the per-FU busy vector that the reservation station uses to select issue candidates. It sits between reservation-station issue and the FU/CDB stage; on squash it clears everything.

Parameters:
SUPERSCALAR_WAYS, 3, number of issue ways per cycle
CDB_W, 3, CDB broadcast slots per cycle
MULT_LAT, 4, multiplier latency in cycles from issue to result ready (legal range 2..15)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
squash  in  1  pipeline flush (mispredict); synchronous
issue_valid  in  SUPERSCALAR_WAYS  issue way j carries an instruction this cycle
issue_fu  in  SUPERSCALAR_WAYS x 3  target FU code per way: 1 ALU_1, 2 ALU_2, 3 ALU_3, 4 MULT_1, 5 MULT_2, 6 BRANCH; 0 and 7 are ignored
fu_busy  out  6  busy per FU; bit 0 alu_1, 1 alu_2, 2 alu_3, 3 mult_1, 4 mult_2, 5 branch_1
cdb_grant  out  6  FU result broadcast this cycle (same bit order as fu_busy)
cdb_valid  out  CDB_W  slot k carries a result
cdb_fu  out  CDB_W x 3  FU code occupying slot k; 0 when the slot is invalid
issue_err  out  1  sticky protocol-error flag

Behaviour:
- Per-FU state machine: IDLE, EXEC (multipliers only), DONE.
  - IDLE -> DONE: ALU or branch accepted issue.
  - IDLE -> EXEC: multiplier accepted issue; down-counter (4 bits) loaded with MULT_LAT-2.
  - EXEC, count>0: decrement. EXEC, count==0: -> DONE.
  - DONE, granted: -> IDLE, or -> DONE/EXEC if re-issued in the same cycle. DONE, not granted: hold.
- Latency:
  - ALU or branch issued in cycle t: request at t+1.
  - Multiplier issued in cycle t: request at t+MULT_LAT.
  - Earliest grant equals earliest request.
- CDB arbitration is combinational from current state.
  - Fixed priority among DONE units: mult_1, mult_2, branch_1, alu_1, alu_2, alu_3.
  - The first CDB_W requesters are granted and packed into slots 0.. in priority order.
  - Unused slots: cdb_valid=0, cdb_fu=0.
  - Ungranted units stay DONE and remain busy.
- fu_busy[f] = (state != IDLE) and not (state == DONE and cdb_grant[f]). A unit freed by grant this cycle is reported free and may accept a new issue in the same cycle.
- Issue acceptance: a way is accepted only if its code is 1..6, fu_busy of that FU is 0, and no lower-numbered way targets the same FU this cycle.
  - Rejected valid issue (busy target or duplicate target): dropped, and issue_err set to 1.
  - issue_err stays 1 until reset.
  - Codes 0/7 are silently ignored.
- squash:
  - All FUs -> IDLE at the next edge; counters cleared.
  - cdb_grant, cdb_valid and cdb_fu are forced to 0 in the squash cycle.
  - Issues in the squash cycle are dropped without setting issue_err.
  - issue_err is not cleared by squash.
- Reset (reset=0, asynchronous): all FUs IDLE, counters 0, fu_busy=0, cdb_grant=0, cdb_valid=0, cdb_fu=0, issue_err=0. Asserting reset mid-multiply abandons the operation with no grant.
- Outputs other than the combinational grant/busy path are registered. No output depends combinationally on issue_valid/issue_fu.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> fu_busy=6'b000000, cdb_valid=3'b000, issue_err=0; with no stimulus, outputs unchanged for 10 cycles.
- Issue ALU_1 on way0 and ALU_2 on way1 at cycle 0 -> cycle 0 fu_busy=0. Cycle 1: cdb_grant=6'b000011, slot0=1, slot1=2, cdb_valid=3'b011, fu_busy=0.
- Issue MULT_1 at cycle 0 (MULT_LAT=4) -> fu_busy[3]=1 in cycles 1-3. Cycle 4: cdb_grant[3]=1, slot0=4, fu_busy[3]=0. Re-issue to MULT_1 at cycle 4 accepted, next grant at cycle 8.
- Contention: bring all six FUs to DONE in the same cycle, CDB_W=3 -> first cycle grants mult_1, mult_2, branch (cdb_fu={4,5,6}, grant=6'b111000) and fu_busy=6'b000111. Next cycle grants codes {1,2,3} (grant=6'b000111), after which fu_busy=0.
- Squash: MULT_2 issued at cycle 0, squash=1 at cycle 2 -> cycle 3 fu_busy=0. No cdb_grant[4] ever observed. issue_err=0.
- Errors:
  - Way0 and way2 both target ALU_3 at cycle 0 -> only way0 accepted; cycle 1 exactly one grant for code 3; issue_err=1 from cycle 1 and still 1 after squash.
  - An issue to a busy MULT_1 during EXEC also sets issue_err.
